pipe_fetch_ctrl: RTL and testbench

Fetch-stage sequencer for the dynamic pipelined CPU. It owns the PC register and picks the next PC from pc+4, branch, register-jump, jump and exception-vector targets. It handles load-use stalls from ID and a variable-latency instruction-memory handshake, buffering any redirect that arrives while a fetch is outstanding. It sits between the IF next-PC mux and the IF/ID pipeline register, and drives `pc` into the instruction memory.

---
 rtl/pipe_fetch_ctrl_pkg.sv | 27 ++
 rtl/pipe_fetch_ctrl_mux4x32.sv | 22 ++
 rtl/pipe_fetch_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_fetch_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_fetch_ctrl_pkg.sv
// Shared definitions for the fetch-stage sequencer: next-PC select codes,
// FSM state encoding, default reset/exception addresses and a PC helper.
package pipe_fetch_ctrl_pkg;

    // pcsource[1:0] encodings
    localparam logic [1:0] PCS_PC4 = 2'b00;
    localparam logic [1:0] PCS_BPC = 2'b01;
    localparam logic [1:0] PCS_RPC = 2'b10;
    localparam logic [1:0] PCS_JPC = 2'b11;

    // Default addresses
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_0008;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } fetch_state_e;

    // Instructions are word aligned; the two low PC bits are always zero.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pipe_fetch_ctrl_mux4x32.sv
// 4:1 32-bit selector used for the next-PC target (pc4/bpc/rpc/jpc).
module mux4x32 (
    input  logic [31:0] a0_i,
    input  logic [31:0] a1_i,
    input  logic [31:0] a2_i,
    input  logic [31:0] a3_i,
    input  logic [1:0]  sel_i,
    output logic [31:0] y_o
);

    // Plain select; every code maps to one input so no default hazard exists
    always_comb begin
        y_o = a0_i;
        case (sel_i)
            2'b00:   y_o = a0_i;
            2'b01:   y_o = a1_i;
            2'b10:   y_o = a2_i;
            default: y_o = a3_i;
        endcase
    end

endmodule

// File: rtl/pipe_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, selects the next PC, handles load-use
// stalls and a variable-latency instruction-memory handshake, and buffers a
// redirect that arrives while the current fetch cannot complete.
// Optional feature macro: PIPE_FETCH_EXC_EN enables the exception path
// (pcsource[2], exc_pc, EXC_VEC redirect and the epc register).
module pipe_fetch_ctrl
    import pipe_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [2:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic [31:0] exc_pc,
    input  logic        stall,
    input  logic        imem_rdy,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        imem_req,
    output logic        if_valid,
    output logic [31:0] epc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         pending_q, pending_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic [31:0]  target;
    logic         exc_req;
    logic         not_boot;
    logic         advance;

`ifdef PIPE_FETCH_EXC_EN
    logic [31:0]  epc_q, epc_d;

    assign exc_req = pcsource[2];
    assign epc     = epc_q;
`else
    logic [32:0]  unused_exc;

    // Exception inputs have no function in this build
    assign unused_exc = {pcsource[2], exc_pc};
    assign exc_req    = 1'b0;
    assign epc        = 32'h0000_0000;
`endif

    assign pc       = pc_q;
    assign pc4      = pc_q + 32'd4;
    assign not_boot = (state_q != BOOT);
    assign advance  = imem_rdy & ~stall & not_boot;
    // A fetch is squashed while a buffered redirect waits or an exception enters
    assign if_valid = imem_rdy & ~stall & ~pending_q & ~exc_req & not_boot;

    // Target select shared by the direct PC update and the redirect buffer
    mux4x32 u_target_mux (
        .a0_i  (pc4),
        .a1_i  (bpc),
        .a2_i  (rpc),
        .a3_i  (jpc),
        .sel_i (pcsource[1:0]),
        .y_o   (target)
    );

    // FSM next state and fetch request
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (!imem_rdy) state_d = WAIT;
            end
            WAIT: begin
                imem_req = 1'b1;
                if (imem_rdy) state_d = FETCH;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Next-PC priority: exception, buffered redirect, live select, capture, hold
    always_comb begin
        pc_d      = pc_q;
        pending_d = pending_q;
        pend_pc_d = pend_pc_q;
`ifdef PIPE_FETCH_EXC_EN
        epc_d     = epc_q;
`endif
        if (exc_req) begin
            pc_d      = EXC_VEC;
            pending_d = 1'b0;
`ifdef PIPE_FETCH_EXC_EN
            epc_d     = exc_pc;
`endif
        end else if (advance && pending_q) begin
            pc_d      = pend_pc_q;
            pending_d = 1'b0;
        end else if (advance) begin
            pc_d      = word_align(target);
        end else if ((pcsource[1:0] != PCS_PC4) && !pending_q) begin
            // ID only presents a redirect once, so remember it until the fetch completes
            pend_pc_d = word_align(target);
            pending_d = 1'b1;
        end
    end

    // Control and PC state, cleared asynchronously so a reset aborts any wait
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
        end
    end

`ifdef PIPE_FETCH_EXC_EN
    // Exception PC capture
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            epc_q <= 32'h0000_0000;
        end else begin
            epc_q <= epc_d;
        end
    end
`endif

    // Buffered redirect target; only meaningful while pending_q is set
    always_ff @(posedge clk) begin
        pend_pc_q <= pend_pc_d;
    end

endmodule

// File: tb/tb_pipe_fetch_ctrl.sv
// Testbench for pipe_fetch_ctrl: table of per-cycle stimulus with hand-derived
// expected outputs, expected records queued on drive and checked at negedge,
// plus hand-written sequences for async reset and the exception path.
module tb_pipe_fetch_ctrl;

    logic        clk = 1'b0;
    logic        clrn;
    logic [2:0]  pcsource;
    logic [31:0] bpc, rpc, jpc, exc_pc;
    logic        stall, imem_rdy;
    logic [31:0] pc, pc4, epc;
    logic        imem_req, if_valid;

    always #5 clk = ~clk;

    pipe_fetch_ctrl dut (
        .clk      (clk),
        .clrn     (clrn),
        .pcsource (pcsource),
        .bpc      (bpc),
        .rpc      (rpc),
        .jpc      (jpc),
        .exc_pc   (exc_pc),
        .stall    (stall),
        .imem_rdy (imem_rdy),
        .pc       (pc),
        .pc4      (pc4),
        .imem_req (imem_req),
        .if_valid (if_valid),
        .epc      (epc)
    );

    typedef struct {
        logic [2:0]  ps;
        logic [31:0] bpc, rpc, jpc, xpc;
        logic        st, rdy;
        logic [31:0] e_pc, e_pc4, e_epc;
        logic        e_ifv, e_req;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] pc, pc4, epc;
        logic        ifv, req;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(input logic [2:0] ps, input logic [31:0] b, input logic [31:0] r,
                                input logic [31:0] j, input logic [31:0] x, input logic st,
                                input logic rdy, input logic [31:0] epcv, input logic [31:0] epc4,
                                input logic ifv, input logic req, input logic [31:0] eepc);
        vec_t v;
        v.ps = ps; v.bpc = b; v.rpc = r; v.jpc = j; v.xpc = x; v.st = st; v.rdy = rdy;
        v.e_pc = epcv; v.e_pc4 = epc4; v.e_ifv = ifv; v.e_req = req; v.e_epc = eepc;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    // Drive a vector's inputs now and queue its expected outputs
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        pcsource = v.ps; bpc = v.bpc; rpc = v.rpc; jpc = v.jpc; exc_pc = v.xpc;
        stall = v.st; imem_rdy = v.rdy;
        e.idx = idx; e.pc = v.e_pc; e.pc4 = v.e_pc4; e.ifv = v.e_ifv; e.req = v.e_req; e.epc = v.e_epc;
        sb.push_back(e);
    endtask

    // Compare the oldest queued expectation against the DUT
    task automatic sample();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard: queue empty, expected one entry");
        end else begin
            e = sb.pop_front();
            chk("pc", e.idx, pc, e.pc);
            chk("pc4", e.idx, pc4, e.pc4);
            chk("if_valid", e.idx, {31'd0, if_valid}, {31'd0, e.ifv});
            chk("imem_req", e.idx, {31'd0, imem_req}, {31'd0, e.req});
            chk("epc", e.idx, epc, e.epc);
        end
    endtask

    // One cycle: drive at posedge+1, check at negedge, move to next posedge+1
    task automatic step(input vec_t v, input int idx);
        apply(v, idx);
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        clrn = 1'b0; pcsource = 3'b000; bpc = '0; rpc = '0; jpc = '0; exc_pc = '0;
        stall = 1'b0; imem_rdy = 1'b1;

        // ps, bpc, rpc, jpc, exc_pc, stall, rdy, pc, pc4, if_valid, imem_req, epc
        add(3'b000, 0, 0, 0, 0, 0, 1, 32'h00, 32'h04, 0, 0, 0);          // 0 BOOT
        add(3'b000, 0, 0, 0, 0, 0, 1, 32'h00, 32'h04, 1, 1, 0);          // 1 first fetch
        add(3'b000, 0, 0, 0, 0, 0, 1, 32'h04, 32'h08, 1, 1, 0);
        add(3'b000, 0, 0, 0, 0, 0, 1, 32'h08, 32'h0C, 1, 1, 0);
        add(3'b000, 0, 0, 0, 0, 0, 1, 32'h0C, 32'h10, 1, 1, 0);
        add(3'b001, 32'h40, 0, 0, 0, 0, 1, 32'h10, 32'h14, 1, 1, 0);     // 5 branch, delay slot valid
        add(3'b010, 0, 32'h20, 0, 0, 0, 1, 32'h40, 32'h44, 1, 1, 0);     // 6 reg jump
        add(3'b011, 0, 0, 32'h80, 0, 0, 0, 32'h20, 32'h24, 0, 1, 0);     // 7 jump under not-ready
        add(3'b000, 0, 0, 0, 0, 0, 0, 32'h20, 32'h24, 0, 1, 0);          // 8 WAIT
        add(3'b000, 0, 0, 0, 0, 0, 1, 32'h20, 32'h24, 0, 1, 0);          // 9 ready, squashed
        add(3'b001, 32'h30, 0, 0, 0, 0, 1, 32'h80, 32'h84, 1, 1, 0);     // 10
        add(3'b000, 0, 0, 0, 0, 1, 1, 32'h30, 32'h34, 0, 1, 0);          // 11 stall
        add(3'b000, 0, 0, 0, 0, 1, 1, 32'h30, 32'h34, 0, 1, 0);          // 12 stall
        add(3'b000, 0, 0, 0, 0, 0, 1, 32'h30, 32'h34, 1, 1, 0);          // 13 resume
        add(3'b000, 0, 0, 0, 0, 0, 1, 32'h34, 32'h38, 1, 1, 0);
        add(3'b000, 0, 0, 0, 0, 1, 0, 32'h38, 32'h3C, 0, 1, 0);          // 15 stall + not-ready
        add(3'b000, 0, 0, 0, 0, 1, 1, 32'h38, 32'h3C, 0, 1, 0);          // 16 WAIT, stalled
        add(3'b000, 0, 0, 0, 0, 0, 1, 32'h38, 32'h3C, 1, 1, 0);          // 17
        add(3'b011, 0, 0, 32'h100, 0, 1, 1, 32'h3C, 32'h40, 0, 1, 0);    // 18 capture under stall
        add(3'b001, 32'h200, 0, 0, 0, 1, 1, 32'h3C, 32'h40, 0, 1, 0);    // 19 second redirect ignored
        add(3'b000, 0, 0, 0, 0, 0, 1, 32'h3C, 32'h40, 0, 1, 0);          // 20 pending applied
        add(3'b010, 0, 32'hFFFF_FFFC, 0, 0, 0, 1, 32'h100, 32'h104, 1, 1, 0);
        add(3'b000, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0, 1, 1, 0);    // 22 wrap
        add(3'b001, 32'h53, 0, 0, 0, 0, 1, 32'h0, 32'h4, 1, 1, 0);       // 23 misaligned target
        add(3'b011, 0, 0, 32'h300, 0, 0, 0, 32'h50, 32'h54, 0, 1, 0);    // 24 enter WAIT, pending

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", -1, pc, 32'h0);
        chk("rst_req", -1, {31'd0, imem_req}, 32'd0);
        chk("rst_ifv", -1, {31'd0, if_valid}, 32'd0);
        chk("rst_epc", -1, epc, 32'h0);
        @(posedge clk);
        #1;
        clrn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        // Still waiting at 0x50 with a buffered jump; reset mid-WAIT
        v = vecs[8];
        v.e_pc = 32'h50; v.e_pc4 = 32'h54;
        apply(v, 100);
        @(negedge clk);
        sample();
        #2;
        clrn = 1'b0;
        #1;
        chk("async_pc", 101, pc, 32'h0);
        chk("async_req", 101, {31'd0, imem_req}, 32'd0);
        chk("async_ifv", 101, {31'd0, if_valid}, 32'd0);
        @(posedge clk);
        #1;
        clrn = 1'b1;
        v = vecs[0]; step(v, 102);                        // BOOT again
        v = vecs[1]; step(v, 103);                        // pending was cleared
        v = vecs[2]; step(v, 104);
        v = vecs[3]; step(v, 105);

`ifdef PIPE_FETCH_EXC_EN
        add(3'b011, 0, 0, 32'h500, 0, 1, 1, 32'h0C, 32'h10, 0, 1, 0);
        add(3'b100, 0, 0, 0, 32'h24, 1, 1, 32'h0C, 32'h10, 0, 1, 0);
        add(3'b000, 0, 0, 0, 0, 0, 1, 32'h08, 32'h0C, 1, 1, 32'h24);
        add(3'b000, 0, 0, 0, 0, 0, 1, 32'h0C, 32'h10, 1, 1, 32'h24);
`else
        add(3'b100, 0, 0, 0, 32'h24, 0, 1, 32'h0C, 32'h10, 1, 1, 0);
        add(3'b000, 0, 0, 0, 0, 0, 1, 32'h10, 32'h14, 1, 1, 0);
`endif
        for (int i = 25; i < vecs.size(); i++) step(vecs[i], 200 + i);

        chk("sb_drained", 300, sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
